seq_detector_param: RTL and testbench

//  Parametrised serial sequence detector, the successor of the fixed 0x55 detector FSM.
//  - Detects a runtime-loadable, maskable PAT_W-bit pattern on a 1-bit serial stream.
//  - Selectable overlapping / non-overlapping detection.
//  - Keeps a saturating hit counter for statistical detection-probability benches.

---
 rtl/seq_detector_pkg.sv | 11 +
 rtl/seq_detector_param_sat_counter.sv | 23 ++
 rtl/seq_detector_param.sv | 74 +++++++
 tb/tb_seq_detector_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
// seq_detector_pkg: shared types and helpers for seq_detector_param
//   seqdet_state_t : FILL (window not yet full) / HUNT (compare every sample)
//   sat_inc        : saturating increment up to a limit
//   PAT_W_MAX      : widest supported pattern
package seq_detector_pkg;
    localparam int PAT_W_MAX = 32;
    typedef enum logic {FILL, HUNT} seqdet_state_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear, wins over inc
//   inc        : count one event
//   q          : current count
module sat_counter
    import seq_detector_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    always_comb q_d = clr ? '0 : (inc && !(&q_q)) ? q_q + 1'b1 : q_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    assign q = q_q;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: maskable, runtime-loadable serial pattern detector
//   clk, reset   : clock, asynchronous active-high reset
//   dataIn/in_en : serial bit and its sample strobe
//   pattern/mask : loaded on cfg_load (MSB = oldest bit, mask 1 = compared)
//   overlap      : 1 = keep hunting after a hit, 0 = restart the window
//   det          : one-cycle registered hit pulse
//   hit_count    : saturating hit counter
//   SEQDET_STATS_EN adds bit_count (saturating sample counter) and clear_stats
module seq_detector_param
    import seq_detector_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(8'h55),
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dataIn,
    input  logic             in_en,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    input  logic             cfg_load,
    input  logic             overlap,
    output logic             det,
`ifdef SEQDET_STATS_EN
    input  logic             clear_stats,
    output logic [CNT_W-1:0] bit_count,
`endif
    output logic [CNT_W-1:0] hit_count
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    logic [PAT_W-1:0] pat_q, pat_d, mask_q, mask_d, shreg_q, shreg_d, shreg_nx;
    logic [FW-1:0] fill_q, fill_d, fill_nx;
    seqdet_state_t state_q, state_d;
    logic det_q, det_d, smp, hit, clr;
    always_comb begin
        shreg_nx = {shreg_q[PAT_W-2:0], dataIn};
        fill_nx  = FW'(sat_inc(32'(fill_q), 32'(PAT_W)));
        // a configuration load swallows any sample in the same cycle
        smp      = in_en && !cfg_load;
        hit      = smp && (state_q == HUNT || fill_nx == FULL) && ((shreg_nx ^ pat_q) & mask_q) == '0;
        pat_d    = cfg_load ? pattern : pat_q;
        mask_d   = cfg_load ? mask : mask_q;
        shreg_d  = cfg_load ? '0 : smp ? shreg_nx : shreg_q;
        fill_d   = (cfg_load || (hit && !overlap)) ? '0 : smp ? fill_nx : fill_q;
        state_d  = (fill_d == FULL) ? HUNT : FILL;
        det_d    = hit;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pat_q   <= PATTERN;
            mask_q  <= '1;
            shreg_q <= '0;
            fill_q  <= '0;
            state_q <= FILL;
            det_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            shreg_q <= shreg_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            det_q   <= det_d;
        end
    assign det = det_q;
`ifdef SEQDET_STATS_EN
    assign clr = clear_stats;
    sat_counter #(.W(CNT_W)) u_bit_cnt (.clk(clk), .reset(reset), .clr(clr), .inc(smp), .q(bit_count));
`else
    assign clr = 1'b0;
`endif
    sat_counter #(.W(CNT_W)) u_hit_cnt (.clk(clk), .reset(reset), .clr(clr), .inc(hit), .q(hit_count));
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: vector table, corner sequences and random stream vs a window model
module tb_seq_detector_param;
    logic clk = 1'b0, reset = 1'b1, dataIn = 1'b0, in_en = 1'b0, cfg_load = 1'b0, overlap = 1'b1;
    logic [7:0] pattern = 8'h55, mask = 8'hFF;
    logic det, det4;
    logic [15:0] hit_count;
    logic [3:0] hit4;
`ifdef SEQDET_STATS_EN
    logic clear_stats = 1'b0;
    logic [15:0] bit_count;
    logic [3:0] bit4;
`endif
    int n_chk = 0, n_pass = 0;
    bit q[$];
    int fresh = 0, m_hits = 0, m_bits = 0;
    logic [7:0] m_pat = 8'h55, m_mask = 8'hFF;
    bit m_det = 1'b0, det_seen = 1'b0;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(8), .PATTERN(8'h55), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .in_en(in_en), .pattern(pattern), .mask(mask),
        .cfg_load(cfg_load), .overlap(overlap), .det(det),
`ifdef SEQDET_STATS_EN
        .clear_stats(clear_stats), .bit_count(bit_count),
`endif
        .hit_count(hit_count));

    seq_detector_param #(.PAT_W(8), .PATTERN(8'h55), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .dataIn(dataIn), .in_en(in_en), .pattern(pattern), .mask(mask),
        .cfg_load(cfg_load), .overlap(overlap), .det(det4),
`ifdef SEQDET_STATS_EN
        .clear_stats(clear_stats), .bit_count(bit4),
`endif
        .hit_count(hit4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int lim);
        return v > lim ? lim : v;
    endfunction

    task automatic chk_counts();
        chk("hit_count", 32'(hit_count), sat(m_hits, 65535));
        chk("hit4", 32'(hit4), sat(m_hits, 15));
`ifdef SEQDET_STATS_EN
        chk("bit_count", 32'(bit_count), sat(m_bits, 65535));
        chk("bit4", 32'(bit4), sat(m_bits, 15));
`endif
    endtask

    // reference: last 8 sampled bits since the last restart, plus fresh-bit count
    task automatic model_sample(input bit b);
        logic [7:0] w;
        q.push_back(b);
        if (q.size() > 8) void'(q.pop_front());
        fresh++;
        m_bits++;
        m_det = 1'b0;
        if (fresh >= 8) begin
            w = '0;
            foreach (q[i]) w = {w[6:0], q[i]};
            if (((w ^ m_pat) & m_mask) == 8'h00) begin
                m_det = 1'b1;
                m_hits++;
                if (!overlap) fresh = 0;
            end
        end
    endtask

    task automatic model_restart();
        q.delete();
        fresh = 0;
        m_pat = pattern;
        m_mask = mask;
    endtask

    task automatic model_reset();
        q.delete();
        fresh = 0;
        m_pat = 8'h55;
        m_mask = 8'hFF;
        m_hits = 0;
        m_bits = 0;
    endtask

    task automatic smp(input bit b);
        dataIn = b;
        in_en = 1'b1;
        @(posedge clk); #1;
        in_en = 1'b0;
        model_sample(b);
        det_seen = det;
        chk("det", 32'(det), 32'(m_det));
        chk("det4", 32'(det4), 32'(m_det));
        chk_counts();
        @(posedge clk); #1;
        chk("det_pulse", 32'(det), 32'd0);
    endtask

    task automatic cfg(input logic [7:0] p, input logic [7:0] m, input bit ien, input bit d);
        pattern = p;
        mask = m;
        cfg_load = 1'b1;
        in_en = ien;
        dataIn = d;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        in_en = 1'b0;
        model_restart();
        chk("cfg_det", 32'(det), 32'd0);
        chk_counts();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_det", 32'(det), 32'd0);
        chk("rst_hit", 32'(hit_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [7:0]  pat;
        logic [7:0]  msk;
        bit          ov;
        logic [15:0] stream;
        int          n;
        logic [15:0] dets;
        int          hits;
    } vec_t;
    vec_t tbl[6];

    initial begin
        logic [15:0] s;
        int base;
        tbl[0] = '{8'h55, 8'hFF, 1'b1, 16'h0055,  8, 16'h0080, 1};
        tbl[1] = '{8'h55, 8'hFF, 1'b1, 16'h0155, 10, 16'h0280, 2};
        tbl[2] = '{8'h55, 8'hFF, 1'b0, 16'h5555, 16, 16'h8080, 2};
        tbl[3] = '{8'hA5, 8'h0F, 1'b1, 16'h00F5,  8, 16'h0080, 1};
        tbl[4] = '{8'hA5, 8'h0F, 1'b1, 16'h00F4,  8, 16'h0000, 0};
        tbl[5] = '{8'h55, 8'h00, 1'b1, 16'h03C5, 10, 16'h0380, 3};

        @(posedge clk); #1;
        chk("reset_det", 32'(det), 32'd0);
        chk("reset_hit", 32'(hit_count), 32'd0);
        chk("reset_hit4", 32'(hit4), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk_counts();

        // scenario 1 straight after reset, with the reset-time pattern
        overlap = 1'b1;
        s = 16'h0055;
        for (int k = 1; k <= 8; k++) begin
            smp(s[8-k]);
            chk("s1_det", 32'(det_seen), 32'(k == 8));
        end
        chk("s1_hits", 32'(hit_count), 32'd1);

        foreach (tbl[r]) begin
            cfg(tbl[r].pat, tbl[r].msk, 1'b0, 1'b0);
            overlap = tbl[r].ov;
            base = m_hits;
            for (int k = 1; k <= tbl[r].n; k++) begin
                s = tbl[r].stream;
                smp(s[tbl[r].n-k]);
                s = tbl[r].dets;
                chk("tbl_det", 32'(det_seen), 32'(s[k-1]));
            end
            chk("tbl_hits", 32'(hit_count), 32'(base + tbl[r].hits));
        end

        // restart after 5 bits: the old partial window must not complete
        overlap = 1'b1;
        cfg(8'h55, 8'hFF, 1'b0, 1'b0);
        s = 16'h0055;
        for (int k = 1; k <= 5; k++) smp(s[8-k]);
        cfg(8'h55, 8'hFF, 1'b0, 1'b0);
        s = 16'h0005;
        for (int k = 1; k <= 3; k++) begin
            smp(s[3-k]);
            chk("restart_nodet", 32'(det_seen), 32'd0);
        end
        s = 16'h0055;
        for (int k = 1; k <= 8; k++) begin
            smp(s[8-k]);
            chk("restart_det", 32'(det_seen), 32'(k == 6 || k == 8));
        end

        // a sample coinciding with cfg_load is dropped
        cfg(8'h55, 8'hFF, 1'b1, 1'b0);
        s = 16'h0055;
        for (int k = 1; k <= 7; k++) begin
            smp(s[7-k]);
            chk("cfg_ien_nodet", 32'(det_seen), 32'd0);
        end

        // reset while det is high drops it without a clock edge
        cfg(8'h55, 8'hFF, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) smp(s[8-k]);
        dataIn = 1'b1;
        in_en = 1'b1;
        @(posedge clk); #1;
        in_en = 1'b0;
        model_sample(1'b1);
        chk("pre_rst_det", 32'(det), 32'd1);
        #2;
        do_reset();
        chk("post_rst_hit4", 32'(hit4), 32'd0);

        // reset after 7 bits discards the partial window
        for (int k = 1; k <= 7; k++) smp(s[8-k]);
        do_reset();
        smp(1'b1);
        chk("rst_window", 32'(det_seen), 32'd0);

        // saturation with mask=0
        do_reset();
        cfg(8'h00, 8'h00, 1'b0, 1'b0);
        overlap = 1'b1;
        for (int k = 0; k < 28; k++) smp(1'($urandom));
        chk("sat_hit4", 32'(hit4), 32'hF);
        chk("sat_hits16", 32'(hit_count), 32'd21);
`ifdef SEQDET_STATS_EN
        chk("sat_bit4", 32'(bit4), 32'hF);
        clear_stats = 1'b1;
        dataIn = 1'b1;
        in_en = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0;
        in_en = 1'b0;
        model_sample(1'b1);
        m_hits = 0;
        m_bits = 0;
        chk("clr_det", 32'(det), 32'd1);
        chk("clr_hit4", 32'(hit4), 32'd0);
        chk("clr_bit4", 32'(bit4), 32'd0);
        chk_counts();
        @(posedge clk); #1;
`endif

        // random stream with occasional reconfiguration
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0)
                cfg(8'($urandom), 8'($urandom & $urandom & $urandom), 1'($urandom), 1'($urandom));
            overlap = ($urandom_range(0, 3) != 0);
            smp(1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
